wav_record_ctrl: RTL and testbench
==================================

Name: wav_record_ctrl

Overview:
Record/playback scheduler for the WM8731 audio path. Gates the ADC capture stage via record_en. Turns its one-cycle wav_wren sample strobes into handshaked writes to a single-port sample memory (SDRAM/DDR front end). On command, reads the stored take back out, one sample per DAC-side request. The memory port has one owner at a time, decided by the state machine.

Parameters:
ADDR_W, 20, sample address width; memory holds 2**ADDR_W 16-bit samples
DATA_W, 16, sample width, matches capture output
MAX_SAMPLES, 2**ADDR_W-1, recording auto-stops when wr_addr reaches this count

Ports:
clock_50M  in  1  system clock, single domain
reset  in  1  asynchronous, active-high reset
start_rec  in  1  one-cycle pulse: begin new recording
start_play  in  1  one-cycle pulse: begin playback of stored take
stop  in  1  one-cycle pulse: end record/playback
wav_wren  in  1  one-cycle strobe from capture stage: new sample valid
wav_in_data  in  DATA_W  sample from capture stage
record_en  out  1  enables capture stage
mem_wr_req  out  1  write request, held until mem_wr_ack
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  DATA_W  write data
mem_wr_ack  in  1  write accepted (same cycle as req)
mem_rd_req  out  1  read request, held until mem_rd_ack
mem_rd_addr  out  ADDR_W  read address
mem_rd_ack  in  1  read done; mem_rd_data valid this cycle
mem_rd_data  in  DATA_W  read data
play_req  in  1  one-cycle pulse from DAC side: next sample wanted
play_data  out  DATA_W  playback sample
play_valid  out  1  one-cycle pulse: play_data updated
rec_len  out  ADDR_W  samples in stored take
busy  out  1  state != IDLE
overflow  out  1  sticky: capture sample dropped
underrun  out  1  sticky: play_req arrived while read outstanding

Behaviour:
- Reset (async): state=IDLE. Every output and internal register is 0, including rec_len, both addresses, sticky flags and the pending bits.
- States: IDLE, RECORD, FLUSH, PLAY.
- IDLE:
  - start_rec: go to RECORD; wr_addr:=0; overflow:=0; record_en=1 from the next cycle.
  - start_play with rec_len!=0: go to PLAY; rd_addr:=0; underrun:=0.
  - start_play with rec_len==0: ignored.
  - Both in the same cycle: start_rec wins.
  - stop is ignored.
- RECORD:
  - wav_wren while no write is pending: latch wav_in_data into mem_wr_data, set wr_pend. mem_wr_req=wr_pend (registered, so req rises one cycle after the strobe).
  - mem_wr_ack with req: clear wr_pend and increment wr_addr the same cycle.
  - wav_wren while wr_pend=1: sample dropped, overflow:=1, held data unchanged.
  - wav_wren coinciding with ack: new sample accepted, wr_pend stays 1.
  - Exit: on stop, or when wr_addr reaches MAX_SAMPLES, record_en:=0 and go to FLUSH. Strobes after exit are ignored.
- FLUSH:
  - Wait until no write or read is pending, then go to IDLE.
  - If leaving RECORD, rec_len:=wr_addr. If leaving PLAY, rec_len is unchanged.
  - Any command in FLUSH is ignored.
- PLAY:
  - play_req while no read is pending: set rd_pend, mem_rd_req=1 next cycle, mem_rd_addr=rd_addr.
  - mem_rd_ack: play_data:=mem_rd_data, play_valid pulses 1 cycle later, rd_pend:=0, rd_addr:=rd_addr+1.
  - play_req while rd_pend=1: underrun:=1; request not queued.
  - After the ack that makes rd_addr==rec_len: go to IDLE.
  - stop: go to FLUSH. Data from an outstanding read is discarded (no play_valid).
- mem_wr_req and mem_rd_req are never high together.
- Request addr/data stay stable while req=1.
- Address arithmetic is unsigned ADDR_W; wrap is impossible because of the MAX_SAMPLES limit.

Optional Feature:
Macro WAV_LOOP_PLAY_EN.
- Defined: in PLAY, rd_addr wraps to 0 after the ack of sample rec_len-1 and playback continues; only stop exits.
- Undefined: playback ends after one pass, as described in Behaviour.

Decomposition:
- Package wav_ctrl_pkg holds:
  - the state encoding (IDLE=0, RECORD=1, FLUSH=2, PLAY=3);
  - the ADDR_W/DATA_W defaults;
  - the MAX_SAMPLES default.
- One sub-module, wav_req_slot: single-entry request holder with load/ack/pending/drop-flag. It is instantiated twice, once for the write path and once for the read path.

Test Plan:
- Record 5 samples 0x0011..0x0015 with mem_wr_ack immediate, then stop → writes to addr 0..4 with the matching data, record_en drops, rec_len=5, busy=0.
- Hold mem_wr_ack low 40 cycles while two wav_wren arrive → first sample is held, second is dropped, overflow=1; after the ack only one write is seen and wr_addr=1.
- start_play with rec_len=3, three play_req with ack 2 cycles after req → three play_valid pulses with data from addr 0,1,2, then IDLE.
- start_rec and start_play in the same cycle → RECORD entered, no mem_rd_req.
- Assert reset mid-RECORD with wr_pend=1 → all outputs 0 immediately (asynchronously), rec_len=0; a subsequent start_play is ignored.
- With WAV_LOOP_PLAY_EN, rec_len=2, 5 play_req → read addresses 0,1,0,1,0; stop → IDLE after the pending ack.

Source files
------------

// File: rtl/wav_ctrl_pkg.sv
// wav_ctrl_pkg: shared state encoding and size defaults for the record/playback controller
package wav_ctrl_pkg;
  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;
  localparam int MAX_SAMPLES_DEF = 2**ADDR_W_DEF - 1;
  typedef enum logic [1:0] {IDLE = 2'd0, RECORD = 2'd1, FLUSH = 2'd2, PLAY = 2'd3} state_t;
endpackage

// File: rtl/wav_req_slot.sv
// wav_req_slot: single-entry request holder with pending bit and sticky drop flag
// Ports: clock_50M/reset (async, active-high); load offers din; ack retires the held entry;
// clr_drop clears the sticky drop flag; pend/data describe the held entry.
// CHAIN lets a load coinciding with ack refill the slot in the same cycle.
module wav_req_slot import wav_ctrl_pkg::*; #(
  parameter int W = DATA_W_DEF,
  parameter bit CHAIN = 1'b1
) (
  input  logic         clock_50M,
  input  logic         reset,
  input  logic         load,
  input  logic         ack,
  input  logic         clr_drop,
  input  logic [W-1:0] din,
  output logic         pend,
  output logic [W-1:0] data,
  output logic         drop
);
  logic take;
  assign take = load && (!pend || (CHAIN && ack));
  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      pend <= 1'b0;
      data <= '0;
      drop <= 1'b0;
    end else begin
      pend <= take || (pend && !ack);
      if (take) data <= din;
      drop <= !clr_drop && (drop || (load && !take));
    end
  end
endmodule

// File: rtl/wav_record_ctrl.sv
// wav_record_ctrl: record/playback scheduler owning the single-port sample memory
// Ports: clock_50M, reset (async, active-high); start_rec/start_play/stop command pulses;
// wav_wren/wav_in_data capture strobe; mem_wr_* and mem_rd_* req/ack memory ports;
// play_req/play_data/play_valid DAC side; record_en, rec_len, busy, overflow, underrun status.
// Define WAV_LOOP_PLAY_EN to make playback wrap to sample 0 until stop.
module wav_record_ctrl import wav_ctrl_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_SAMPLES = 2**ADDR_W - 1
) (
  input  logic              clock_50M,
  input  logic              reset,
  input  logic              start_rec,
  input  logic              start_play,
  input  logic              stop,
  input  logic              wav_wren,
  input  logic [DATA_W-1:0] wav_in_data,
  output logic              record_en,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_wr_ack,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_ack,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic              play_req,
  output logic [DATA_W-1:0] play_data,
  output logic              play_valid,
  output logic [ADDR_W-1:0] rec_len,
  output logic              busy,
  output logic              overflow,
  output logic              underrun
);
`ifdef WAV_LOOP_PLAY_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif
  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_SAMPLES);
  state_t state, nxt;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic wr_pend, rd_pend, wr_ack, rd_ack, rec_exit, last, from_rec, play_ok, rd_take;
  assign wr_ack = mem_wr_ack && wr_pend;
  assign rd_ack = mem_rd_ack && rd_pend;
  assign rec_exit = stop || wr_addr == MAX_ADDR;
  assign last = ADDR_W'(rd_addr + 1'b1) == rec_len;
  assign play_ok = state == IDLE && !start_rec && start_play && rec_len != '0;
  // a stop in the same cycle as the read ack discards that sample
  assign rd_take = state == PLAY && rd_ack && !stop;
  assign record_en = state == RECORD;
  assign busy = state != IDLE;
  assign mem_wr_req = wr_pend;
  assign mem_rd_req = rd_pend;
  assign mem_wr_addr = wr_addr;
  wav_req_slot #(.W(DATA_W), .CHAIN(1'b1)) u_wr (
    .clock_50M(clock_50M), .reset(reset),
    .load(state == RECORD && wav_wren && !rec_exit), .ack(wr_ack),
    .clr_drop(state == IDLE && start_rec), .din(wav_in_data),
    .pend(wr_pend), .data(mem_wr_data), .drop(overflow)
  );
  // read slot holds the request address; a play_req with a read outstanding is never queued
  wav_req_slot #(.W(ADDR_W), .CHAIN(1'b0)) u_rd (
    .clock_50M(clock_50M), .reset(reset),
    .load(state == PLAY && play_req && !stop), .ack(rd_ack),
    .clr_drop(play_ok), .din(rd_addr),
    .pend(rd_pend), .data(mem_rd_addr), .drop(underrun)
  );
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start_rec ? RECORD : play_ok ? PLAY : IDLE;
      RECORD:  nxt = rec_exit ? FLUSH : RECORD;
      FLUSH:   nxt = (wr_pend || rd_pend) ? FLUSH : IDLE;
      default: nxt = stop ? FLUSH : (rd_ack && last && !LOOP) ? IDLE : PLAY;
    endcase
  end
  always_ff @(posedge clock_50M or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wr_addr <= '0;
      rd_addr <= '0;
      rec_len <= '0;
      from_rec <= 1'b0;
      play_data <= '0;
      play_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && start_rec) wr_addr <= '0;
      else if (wr_ack) wr_addr <= wr_addr + 1'b1;
      if (play_ok) rd_addr <= '0;
      else if (rd_ack) rd_addr <= (LOOP && last) ? '0 : rd_addr + 1'b1;
      // FLUSH remembers whether it was entered from RECORD so only a take updates rec_len
      if (state != FLUSH) from_rec <= state == RECORD;
      if (state == FLUSH && nxt == IDLE && from_rec) rec_len <= wr_addr;
      if (rd_take) play_data <= mem_rd_data;
      play_valid <= rd_take;
    end
  end
endmodule

// File: tb/tb_wav_record_ctrl.sv
// tb_wav_record_ctrl: scoreboard bench for wav_record_ctrl with a small memory responder
module tb_wav_record_ctrl;
  localparam int AW = 20;
  localparam int DW = 16;
  logic clock_50M = 1'b0;
  logic reset = 1'b1;
  logic start_rec = 1'b0, start_play = 1'b0, stop = 1'b0, wav_wren = 1'b0, play_req = 1'b0;
  logic [DW-1:0] wav_in_data = '0;
  logic record_en, mem_wr_req, mem_wr_ack, mem_rd_req, play_valid, busy, overflow, underrun;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr, rec_len;
  logic [DW-1:0] mem_wr_data, play_data;
  logic mem_rd_ack = 1'b0;
  logic [DW-1:0] mem_rd_data = '0;
  logic wr_ack_en = 1'b1;
  int rd_lat = 2;
  int rcnt = 0;
  int errs = 0, checks = 0, wr_seen = 0, pv_cnt = 0;
  logic [DW-1:0] mem [int];
  logic [AW-1:0] wa_q [$];
  logic [DW-1:0] wd_q [$];
  logic [AW-1:0] ra_q [$];
  logic [DW-1:0] pd_q [$];

  always #5 clock_50M = ~clock_50M;
  assign mem_wr_ack = mem_wr_req & wr_ack_en;

  wav_record_ctrl #(.ADDR_W(AW), .DATA_W(DW), .MAX_SAMPLES(8)) dut (
    .clock_50M(clock_50M), .reset(reset), .start_rec(start_rec), .start_play(start_play),
    .stop(stop), .wav_wren(wav_wren), .wav_in_data(wav_in_data), .record_en(record_en),
    .mem_wr_req(mem_wr_req), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_wr_ack(mem_wr_ack), .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data), .play_req(play_req),
    .play_data(play_data), .play_valid(play_valid), .rec_len(rec_len), .busy(busy),
    .overflow(overflow), .underrun(underrun)
  );

  always @(negedge clock_50M) begin
    if (!reset && (mem_wr_req || mem_rd_req)) begin
      checks++;
      if (mem_wr_req && mem_rd_req) begin errs++; $display("FAIL req_excl: both requests high"); end
    end
    if (!reset && mem_wr_req && mem_wr_ack) begin
      checks++;
      wr_seen++;
      mem[int'(mem_wr_addr)] = mem_wr_data;
      if (wa_q.size() == 0) begin
        errs++; $display("FAIL wr_unexpected: addr=%h data=%h", mem_wr_addr, mem_wr_data);
      end else begin
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        ea = wa_q.pop_front();
        ed = wd_q.pop_front();
        if ({mem_wr_addr, mem_wr_data} !== {ea, ed}) begin
          errs++; $display("FAIL wr_xfer: got %h/%h want %h/%h", mem_wr_addr, mem_wr_data, ea, ed);
        end
      end
    end
    if (play_valid) begin
      checks++;
      pv_cnt++;
      if (pd_q.size() == 0) begin
        errs++; $display("FAIL play_unexpected: data=%h", play_data);
      end else begin
        logic [DW-1:0] ep;
        ep = pd_q.pop_front();
        if (play_data !== ep) begin errs++; $display("FAIL play_data: got %h want %h", play_data, ep); end
      end
    end
  end

  always @(negedge clock_50M) begin
    if (reset || mem_rd_ack) begin
      mem_rd_ack = 1'b0;
      rcnt = 0;
    end else if (mem_rd_req) begin
      rcnt++;
      if (rcnt >= rd_lat) begin
        mem_rd_ack = 1'b1;
        mem_rd_data = mem.exists(int'(mem_rd_addr)) ? mem[int'(mem_rd_addr)] : 16'hdead;
        checks++;
        if (ra_q.size() == 0) begin
          errs++; $display("FAIL rd_unexpected: addr=%h", mem_rd_addr);
        end else begin
          logic [AW-1:0] er;
          er = ra_q.pop_front();
          if (mem_rd_addr !== er) begin errs++; $display("FAIL rd_addr: got %h want %h", mem_rd_addr, er); end
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock_50M); #1; end
  endtask

  task automatic cmd(input bit r, input bit p, input bit s);
    start_rec = r; start_play = p; stop = s;
    tick();
    start_rec = 1'b0; start_play = 1'b0; stop = 1'b0;
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    wav_in_data = d; wav_wren = 1'b1;
    tick();
    wav_wren = 1'b0;
  endtask

  task automatic preq();
    play_req = 1'b1;
    tick();
    play_req = 1'b0;
  endtask

  task automatic wait_idle(input int lim, input string nm);
    int n = 0;
    while (busy && n < lim) begin @(negedge clock_50M); n++; end
    checks++;
    if (busy) begin errs++; $display("FAIL %s_timeout: busy=%b want 0", nm, busy); end
  endtask

  task automatic record_take(input int n, input logic [DW-1:0] base);
    cmd(1, 0, 0);
    for (int i = 0; i < n; i++) begin
      wa_q.push_back(AW'(i)); wd_q.push_back(DW'(base + i));
      strobe(DW'(base + i)); tick(2);
    end
    cmd(0, 0, 1);
    wait_idle(10, "take");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(3);
    @(negedge clock_50M);
    checks++;
    if ({record_en, mem_wr_req, mem_rd_req, play_valid, busy, overflow, underrun, rec_len} !== '0) begin
      errs++; $display("FAIL reset_state: en=%b wr=%b rd=%b busy=%b len=%h want all 0",
                       record_en, mem_wr_req, mem_rd_req, busy, rec_len);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_record();
    int w0 = wr_seen;
    cmd(1, 0, 0);
    @(negedge clock_50M);
    checks++;
    if ({record_en, busy} !== 2'b11) begin errs++; $display("FAIL rec_start: en=%b busy=%b want 1 1", record_en, busy); end
    tick();
    for (int i = 0; i < 5; i++) begin
      wa_q.push_back(AW'(i)); wd_q.push_back(DW'(16'h0011 + i));
      strobe(DW'(16'h0011 + i)); tick(2);
    end
    cmd(0, 0, 1);
    wait_idle(10, "rec_stop");
    @(negedge clock_50M);
    checks++;
    if (record_en !== 1'b0 || rec_len !== AW'(5) || wr_seen - w0 != 5) begin
      errs++; $display("FAIL rec_done: en=%b len=%0d writes=%0d want 0 5 5", record_en, rec_len, wr_seen - w0);
    end
  endtask

  task automatic test_overflow();
    int w0 = wr_seen;
    wr_ack_en = 1'b0;
    cmd(1, 0, 0);
    wa_q.push_back('0); wd_q.push_back(16'h00a1);
    strobe(16'h00a1); tick(3);
    strobe(16'h00a2);
    @(negedge clock_50M);
    checks++;
    if ({overflow, mem_wr_req, mem_wr_data} !== {1'b1, 1'b1, 16'h00a1}) begin
      errs++; $display("FAIL ovf_hold: ovf=%b req=%b data=%h want 1 1 00a1", overflow, mem_wr_req, mem_wr_data);
    end
    tick(34);
    wr_ack_en = 1'b1;
    tick(4);
    checks++;
    if (wr_seen - w0 != 1 || mem_wr_req !== 1'b0) begin
      errs++; $display("FAIL ovf_writes: writes=%0d req=%b want 1 0", wr_seen - w0, mem_wr_req);
    end
    cmd(0, 0, 1);
    wait_idle(10, "ovf_stop");
    checks++;
    if (rec_len !== AW'(1)) begin errs++; $display("FAIL ovf_len: got %0d want 1", rec_len); end
  endtask

  task automatic test_play();
    int p0;
    record_take(3, 16'h0031);
    checks++;
    if ({overflow, rec_len} !== {1'b0, AW'(3)}) begin
      errs++; $display("FAIL take3: ovf=%b len=%0d want 0 3", overflow, rec_len);
    end
    p0 = pv_cnt;
    rd_lat = 2;
    cmd(0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      ra_q.push_back(AW'(i)); pd_q.push_back(DW'(16'h0031 + i));
      preq(); tick(5);
    end
    checks++;
    if ({busy, underrun} !== 2'b00 || pv_cnt - p0 != 3) begin
      errs++; $display("FAIL play_done: busy=%b und=%b valids=%0d want 0 0 3", busy, underrun, pv_cnt - p0);
    end
  endtask

  task automatic test_underrun();
    int p0 = pv_cnt;
    rd_lat = 4;
    cmd(0, 1, 0);
    ra_q.push_back('0);
    play_req = 1'b1; tick(2); play_req = 1'b0;
    @(negedge clock_50M);
    checks++;
    if ({underrun, mem_rd_req} !== 2'b11) begin errs++; $display("FAIL und_flag: und=%b req=%b want 1 1", underrun, mem_rd_req); end
    cmd(0, 0, 1);
    wait_idle(10, "und_stop");
    tick(2);
    checks++;
    if (pv_cnt != p0 || rec_len !== AW'(3) || ra_q.size() != 0) begin
      errs++; $display("FAIL und_discard: valids=%0d len=%0d pend=%0d want 0 3 0", pv_cnt - p0, rec_len, ra_q.size());
    end
    rd_lat = 2;
  endtask

  task automatic test_both_cmd();
    int bad = 0;
    cmd(1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_50M);
      if (mem_rd_req !== 1'b0 || record_en !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errs++; $display("FAIL both_cmd: bad cycles=%0d want 0", bad); end
    tick();
    cmd(0, 0, 1);
    wait_idle(10, "both_stop");
    checks++;
    if (rec_len !== '0) begin errs++; $display("FAIL both_len: got %0d want 0", rec_len); end
  endtask

  task automatic test_max();
    int w0 = wr_seen;
    cmd(1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin wa_q.push_back(AW'(i)); wd_q.push_back(DW'(16'h0080 + i)); end
      strobe(DW'(16'h0080 + i)); tick();
    end
    wait_idle(10, "max");
    checks++;
    if ({record_en, rec_len} !== {1'b0, AW'(8)} || wr_seen - w0 != 8) begin
      errs++; $display("FAIL max_stop: en=%b len=%0d writes=%0d want 0 8 8", record_en, rec_len, wr_seen - w0);
    end
  endtask

  task automatic test_reset_mid();
    wr_ack_en = 1'b0;
    cmd(1, 0, 0);
    strobe(16'h0bad);
    @(negedge clock_50M);
    checks++;
    if (mem_wr_req !== 1'b1) begin errs++; $display("FAIL mid_pend: req=%b want 1", mem_wr_req); end
    @(posedge clock_50M); #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({record_en, mem_wr_req, mem_wr_addr, mem_wr_data, mem_rd_req, play_valid, play_data,
         busy, overflow, underrun, rec_len} !== '0) begin
      errs++; $display("FAIL async_reset: en=%b req=%b data=%h busy=%b len=%0d want all 0",
                       record_en, mem_wr_req, mem_wr_data, busy, rec_len);
    end
    tick(2);
    reset = 1'b0;
    wr_ack_en = 1'b1;
    tick();
    cmd(0, 1, 0);
    tick(3);
    checks++;
    if ({busy, mem_rd_req} !== 2'b00) begin errs++; $display("FAIL play_empty: busy=%b req=%b want 0 0", busy, mem_rd_req); end
  endtask

`ifdef WAV_LOOP_PLAY_EN
  task automatic test_loop();
    record_take(2, 16'h0051);
    rd_lat = 2;
    cmd(0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      ra_q.push_back(AW'(i % 2)); pd_q.push_back(DW'(16'h0051 + i % 2));
      preq(); tick(5);
    end
    checks++;
    if (busy !== 1'b1) begin errs++; $display("FAIL loop_busy: got %b want 1", busy); end
    ra_q.push_back(AW'(1));
    preq();
    cmd(0, 0, 1);
    wait_idle(10, "loop_stop");
  endtask
`endif

  initial begin
    test_reset();
    test_record();
    test_overflow();
    test_play();
    test_underrun();
    test_both_cmd();
    test_max();
    test_reset_mid();
`ifdef WAV_LOOP_PLAY_EN
    test_loop();
`endif
    tick(4);
    checks++;
    if (wa_q.size() + ra_q.size() + pd_q.size() != 0) begin
      errs++; $display("FAIL leftover: wr=%0d rd=%0d play=%0d want 0", wa_q.size(), ra_q.size(), pd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
